// File: rtl/switch_out_port.sv
// Output port: byte FIFO with store-and-forward / cut-through release toward a slow consumer.
// Optional statistics (tx_pkt_cnt, ovf) are built when OUT_PORT_STATS_EN is defined.
module switch_out_port #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             slow_clk,
  input  logic             reset_b,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_stall,
  input  logic             read,
  output logic             ready,
  output logic [WIDTH-1:0] port
`ifdef OUT_PORT_STATS_EN
  ,
  output logic [7:0]       tx_pkt_cnt,
  output logic             ovf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, CT} state_t;

  state_t         state;
  logic [WIDTH:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, pkt_cnt;
  logic           push, pop, push_last, pop_last;
  logic [WIDTH:0] head;

  assign in_stall  = (count == CW'(DEPTH));
  assign ready     = (state == SEND) || ((state == CT) && (count != '0));
  assign push      = in_valid && !in_stall;
  assign pop       = read && ready;
  assign head      = mem[rd_ptr];
  assign push_last = push && in_last;
  assign pop_last  = pop && head[WIDTH];

  // Storage carries no reset; only pointers and counts define validity.
  always_ff @(posedge slow_clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  always_ff @(posedge slow_clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      port   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        port   <= head[WIDTH-1:0];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge slow_clk or negedge reset_b) begin
    if (!reset_b) begin
      pkt_cnt <= '0;
    end else begin
      case ({push_last, pop_last})
        2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // A packet is released only once complete, unless the FIFO fills first.
  always_ff @(posedge slow_clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (pkt_cnt != '0)              state <= SEND;
          else if (count == CW'(DEPTH))   state <= CT;
        end
        SEND:    if (pop_last) state <= IDLE;
        CT:      if (pop_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OUT_PORT_STATS_EN
  always_ff @(posedge slow_clk or negedge reset_b) begin
    if (!reset_b) begin
      tx_pkt_cnt <= '0;
      ovf        <= 1'b0;
    end else begin
      if (pop_last)             tx_pkt_cnt <= tx_pkt_cnt + 8'd1;
      if (in_valid && in_stall) ovf        <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_switch_out_port.sv
// Bench for switch_out_port: queue-based reference model checked every cycle plus directed literal checks.
module tb_switch_out_port;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             slow_clk = 1'b0;
  logic             reset_b  = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data  = '0;
  logic             in_last  = 1'b0;
  logic             read     = 1'b0;
  logic             in_stall, ready;
  logic [WIDTH-1:0] port;
`ifdef OUT_PORT_STATS_EN
  logic [7:0]       tx_pkt_cnt;
  logic             ovf;
`endif

  switch_out_port #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .slow_clk (slow_clk),
    .reset_b  (reset_b),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_stall (in_stall),
    .read     (read),
    .ready    (ready),
    .port     (port)
`ifdef OUT_PORT_STATS_EN
    ,
    .tx_pkt_cnt (tx_pkt_cnt),
    .ovf        (ovf)
`endif
  );

  always #5 slow_clk = ~slow_clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, release mode 0=idle 1=send 2=cut-through.
  logic [WIDTH:0]   q[$];
  int               mode;
  logic [WIDTH-1:0] mport;
  logic [7:0]       mtx;
  logic             movf;

  function automatic void model_clear();
    q.delete();
    mode  = 0;
    mport = '0;
    mtx   = '0;
    movf  = 1'b0;
  endfunction

  function automatic bit m_ready();
    return (mode == 1) || (mode == 2 && q.size() != 0);
  endfunction

  function automatic bit m_stall();
    return q.size() == DEPTH;
  endfunction

  function automatic int complete_pkts();
    int n = 0;
    foreach (q[i]) if (q[i][WIDTH]) n++;
    return n;
  endfunction

  always @(posedge slow_clk) begin
    if (reset_b) begin
      bit r, st, do_pop, do_push, popped_last;
      int npk, sz;
      logic [WIDTH:0] e;
      r = m_ready();
      st = m_stall();
      npk = complete_pkts();
      sz = q.size();
      do_pop = read && r;
      do_push = in_valid && !st;
      popped_last = 0;
      if (do_pop) begin
        e = q.pop_front();
        mport = e[WIDTH-1:0];
        popped_last = e[WIDTH];
        if (popped_last) mtx = mtx + 8'd1;
      end
      if (in_valid && st) movf = 1'b1;
      if (mode == 0) begin
        if (npk != 0) mode = 1;
        else if (sz == DEPTH) mode = 2;
      end else if (popped_last) begin
        mode = 0;
      end
      if (do_push) q.push_back({in_last, in_data});
    end
  end

  always @(negedge slow_clk) begin
    check("cyc_ready", 32'(ready), 32'(m_ready()));
    check("cyc_in_stall", 32'(in_stall), 32'(m_stall()));
    check("cyc_port", 32'(port), 32'(mport));
`ifdef OUT_PORT_STATS_EN
    check("cyc_tx_pkt_cnt", 32'(tx_pkt_cnt), 32'(mtx));
    check("cyc_ovf", 32'(ovf), 32'(movf));
`endif
  end

  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    model_clear();
    tick();
    reset_b = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int sent;
    model_clear();
    #1 reset_b = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(ready), 0);
    check("rst_port", 32'(port), 0);
    check("rst_in_stall", 32'(in_stall), 0);
    reset_b = 1'b1;

    // Three-byte packet, read held high
    read = 1'b1;
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b1);
    check("p1_ready_after_last_push", 32'(ready), 0);
    tick(); check("p1_ready_rise", 32'(ready), 1);
    tick(); check("p1_port0", 32'(port), 32'h11);
    tick(); check("p1_port1", 32'(port), 32'h22);
    tick(); check("p1_port2", 32'(port), 32'h33);
    check("p1_ready_drop", 32'(ready), 0);

    // Two queued two-byte packets: one ready-low gap between them
    read = 1'b0;
    push_byte(8'hA1, 1'b0);
    push_byte(8'hA2, 1'b1);
    push_byte(8'hB1, 1'b0);
    push_byte(8'hB2, 1'b1);
    check("p2_paused_ready", 32'(ready), 1);
    check("p2_paused_port", 32'(port), 32'h33);
    read = 1'b1;
    tick(); check("p2_a1", 32'(port), 32'hA1); check("p2_a1_rdy", 32'(ready), 1);
    tick(); check("p2_a2", 32'(port), 32'hA2); check("p2_gap", 32'(ready), 0);
    tick(); check("p2_gap_end", 32'(ready), 1);
    tick(); check("p2_b1", 32'(port), 32'hB1);
    tick(); check("p2_b2", 32'(port), 32'hB2); check("p2_end", 32'(ready), 0);

    // Fill without in_last: cut-through, overflow, full push+pop
    read = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h40 + i), 1'b0);
    check("full_stall", 32'(in_stall), 1);
    check("full_not_ready", 32'(ready), 0);
    push_byte(8'hEE, 1'b0);
    check("ct_ready", 32'(ready), 1);
    check("ct_still_full", 32'(in_stall), 1);
`ifdef OUT_PORT_STATS_EN
    check("ovf_set", 32'(ovf), 1);
`endif
    read = 1'b1;
    push_byte(8'hEF, 1'b0);
    read = 1'b0;
    check("full_pushpop_stall", 32'(in_stall), 0);
    check("full_pushpop_port", 32'(port), 32'h40);
    read = 1'b1;
    repeat (DEPTH - 1) tick();
    check("ct_drained_port", 32'(port), 32'h4F);
    check("ct_empty_not_ready", 32'(ready), 0);
    push_byte(8'h77, 1'b1);
    check("ct_last_ready", 32'(ready), 1);
    tick(); check("ct_last_port", 32'(port), 32'h77); check("ct_exit", 32'(ready), 0);

    // Reset mid-packet
    read = 1'b0;
    push_byte(8'hC1, 1'b0);
    push_byte(8'hC2, 1'b0);
    push_byte(8'hC3, 1'b0);
    push_byte(8'hC4, 1'b1);
    tick();
    read = 1'b1;
    tick(); tick();
    check("mid_port", 32'(port), 32'hC2);
    read = 1'b0;
    reset_b = 1'b0;
    model_clear();
    #1;
    check("mid_rst_ready", 32'(ready), 0);
    check("mid_rst_port", 32'(port), 0);
    check("mid_rst_stall", 32'(in_stall), 0);
    tick();
    reset_b = 1'b1;
    read = 1'b1;
    push_byte(8'hA5, 1'b1);
    tick(); check("new_pkt_ready", 32'(ready), 1);
    tick(); check("new_pkt_port", 32'(port), 32'hA5); check("new_pkt_alone", 32'(ready), 0);
    tick(); check("new_pkt_no_leftover", 32'(ready), 0);

`ifdef OUT_PORT_STATS_EN
    // 257 single-byte packets wrap the transmit counter to 1
    do_reset();
    read = 1'b1;
    sent = 0;
    for (int c = 0; c < 3000 && sent < 257; c++) begin
      in_valid = !in_stall;
      in_data  = 8'(c);
      in_last  = 1'b1;
      tick();
      if (in_valid) sent++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("stats_sent", 32'(sent), 257);
    repeat (120) tick();
    check("stats_tx_wrap", 32'(tx_pkt_cnt), 1);
    check("stats_no_ovf", 32'(ovf), 0);
`endif

    // Randomized traffic, checked cycle by cycle against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        in_valid = 1'b0;
        do_reset();
      end
      in_valid = ($urandom_range(0, 99) < 60);
      in_data  = 8'($urandom);
      in_last  = ($urandom_range(0, 3) == 0);
      read     = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 70 : 25));
      tick();
    end
    in_valid = 1'b0;
    read = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
